// File: rtl/if_id_pipe_pkg.sv
// Shared definitions for the IF/ID pipeline register:
// FSM state encoding and the decode bubble.
package if_id_pipe_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [15:0] BUBBLE = 16'h0000;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with fetch PC, one-entry skid buffer
// and a BOOT/RUN/HOLD control FSM for Thumb fetch.
module if_id_pipe
    import if_id_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IF_PC,
    input  logic [15:0] FINST,
    input  logic        INST_VALID,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [31:0] FLUSH_PC,
    output logic [31:0] PC,
    output logic [31:0] ID_PC,
    output logic [15:0] ID_INST,
    output logic        ID_VALID,
    output logic [15:0] FETCH_CNT
);

    state_t      state, state_n;
    logic [31:0] pc_n, id_pc_n, skid_pc, skid_pc_n;
    logic [15:0] id_inst_n, cnt_n, skid_inst, skid_inst_n;
    logic        id_valid_n, skid_valid, skid_valid_n;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= BOOT;
            PC         <= align_pc(RESET_VECTOR);
            ID_PC      <= 32'h0;
            ID_INST    <= BUBBLE;
            ID_VALID   <= 1'b0;
            FETCH_CNT  <= 16'h0;
            skid_pc    <= 32'h0;
            skid_inst  <= BUBBLE;
            skid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            PC         <= pc_n;
            ID_PC      <= id_pc_n;
            ID_INST    <= id_inst_n;
            ID_VALID   <= id_valid_n;
            FETCH_CNT  <= cnt_n;
            skid_pc    <= skid_pc_n;
            skid_inst  <= skid_inst_n;
            skid_valid <= skid_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = PC;
        id_pc_n      = ID_PC;
        id_inst_n    = ID_INST;
        id_valid_n   = ID_VALID;
        cnt_n        = FETCH_CNT;
        skid_pc_n    = skid_pc;
        skid_inst_n  = skid_inst;
        skid_valid_n = skid_valid;

        // A redirect overrides everything, including a pending skid entry
        if (FLUSH) begin
            pc_n         = align_pc(FLUSH_PC);
            id_valid_n   = 1'b0;
            id_inst_n    = BUBBLE;
            skid_valid_n = 1'b0;
            skid_pc_n    = 32'h0;
            skid_inst_n  = BUBBLE;
            state_n      = BOOT;
        end else begin
            unique case (state)
                BOOT: state_n = RUN;
                RUN: begin
                    if (INST_VALID && !STALL) begin
                        id_pc_n    = PC;
                        id_inst_n  = FINST;
                        id_valid_n = 1'b1;
                        pc_n       = align_pc(IF_PC);
                        cnt_n      = FETCH_CNT + 16'd1;
                    end else if (INST_VALID && STALL) begin
                        // Read data is single-cycle; park it so it is not lost
                        skid_pc_n    = PC;
                        skid_inst_n  = FINST;
                        skid_valid_n = 1'b1;
                        pc_n         = align_pc(IF_PC);
                        state_n      = HOLD;
                    end else if (!STALL) begin
                        id_valid_n = 1'b0;
                        id_inst_n  = BUBBLE;
                    end
                end
                HOLD: begin
                    if (!STALL) begin
                        id_pc_n      = skid_pc;
                        id_inst_n    = skid_inst;
                        id_valid_n   = 1'b1;
                        cnt_n        = FETCH_CNT + 16'd1;
                        skid_valid_n = 1'b0;
                        skid_pc_n    = 32'h0;
                        skid_inst_n  = BUBBLE;
                        state_n      = RUN;
                    end
                end
                default: state_n = BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
// Scoreboard bench for if_id_pipe: directed fetch, stall,
// flush, counter-wrap and reset-during-stall scenarios.
module tb_if_id_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IF_PC;
    logic [15:0] FINST;
    logic        INST_VALID;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] FLUSH_PC;
    logic [31:0] PC;
    logic [31:0] ID_PC;
    logic [15:0] ID_INST;
    logic        ID_VALID;
    logic [15:0] FETCH_CNT;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] inst;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] last_cnt = 16'h0;

    function automatic logic [15:0] inst_of(input logic [31:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    // Fetch datapath stand-in: +2 with bit 0 deliberately set
    assign IF_PC = PC + 32'd3;
    assign FINST = inst_of(PC);

    always #5 CLK = ~CLK;

    if_id_pipe #(.RESET_VECTOR(32'h100)) dut (
        .CLK(CLK), .RST(RST), .IF_PC(IF_PC), .FINST(FINST),
        .INST_VALID(INST_VALID), .STALL(STALL), .FLUSH(FLUSH),
        .FLUSH_PC(FLUSH_PC), .PC(PC), .ID_PC(ID_PC),
        .ID_INST(ID_INST), .ID_VALID(ID_VALID),
        .FETCH_CNT(FETCH_CNT)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [15:0] c);
        exp_t e;
        e.pc   = a;
        e.inst = inst_of(a);
        e.cnt  = c;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic iv, input logic st,
                       input logic fl, input logic [31:0] fpc);
        INST_VALID = iv;
        STALL      = st;
        FLUSH      = fl;
        FLUSH_PC   = fpc;
        @(negedge CLK);
    endtask

    // Monitor: every FETCH_CNT change marks a delivery into ID
    always @(negedge CLK) begin
        if (RST) begin
            last_cnt = 16'h0;
        end else if (FETCH_CNT !== last_cnt) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_delivery: ID_PC %h cnt %h",
                         ID_PC, FETCH_CNT);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("deliv_valid", {31'h0, ID_VALID}, 32'h1);
                chk("deliv_pc", ID_PC, e.pc);
                chk("deliv_inst", {16'h0, ID_INST}, {16'h0, e.inst});
                chk("deliv_cnt", {16'h0, FETCH_CNT}, {16'h0, e.cnt});
            end
            last_cnt = FETCH_CNT;
        end
    end

    initial begin
        logic [31:0] a;
        logic [15:0] c;
        RST = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge CLK);
        chk("rst_pc", PC, 32'h100);
        chk("rst_id_pc", ID_PC, 32'h0);
        chk("rst_id_inst", {16'h0, ID_INST}, 32'h0);
        chk("rst_id_valid", {31'h0, ID_VALID}, 32'h0);
        chk("rst_cnt", {16'h0, FETCH_CNT}, 32'h0);

        RST = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("boot_id_valid", {31'h0, ID_VALID}, 32'h0);
        chk("boot_pc", PC, 32'h100);
        push(32'h100, 16'd1);
        push(32'h102, 16'd2);
        push(32'h104, 16'd3);
        push(32'h106, 16'd4);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            chk("stream_id_pc", ID_PC, 32'h100 + 32'(2 * i));
        end
        chk("stream_cnt", {16'h0, FETCH_CNT}, 32'd4);
        chk("stream_pc", PC, 32'h108);

        cyc(1'b1, 1'b0, 1'b1, 32'h100);
        chk("flush1_pc", PC, 32'h100);
        chk("flush1_valid", {31'h0, ID_VALID}, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        push(32'h100, 16'd5);
        push(32'h102, 16'd6);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            chk("stall_pc", PC, 32'h106);
            chk("stall_id_pc", ID_PC, 32'h102);
            chk("stall_id_valid", {31'h0, ID_VALID}, 32'h1);
        end
        push(32'h104, 16'd7);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("unskid_id_pc", ID_PC, 32'h104);
        chk("unskid_pc", PC, 32'h106);
        push(32'h106, 16'd8);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("after_skid_id_pc", ID_PC, 32'h106);

        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("hold2_pc", PC, 32'h10A);
        cyc(1'b1, 1'b1, 1'b1, 32'h201);
        chk("flush_hold_pc", PC, 32'h200);
        chk("flush_hold_valid", {31'h0, ID_VALID}, 32'h0);
        chk("flush_hold_inst", {16'h0, ID_INST}, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        push(32'h200, 16'd9);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("post_flush_id_pc", ID_PC, 32'h200);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'(i), 1'b0, 32'h0);
            chk("bubble_valid", {31'h0, ID_VALID}, 32'h0);
            chk("bubble_inst", {16'h0, ID_INST}, 32'h0);
            chk("bubble_id_pc", ID_PC, 32'h200);
            chk("bubble_pc", PC, 32'h202);
        end
        push(32'h202, 16'd10);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);

        a = 32'h204;
        c = 16'd10;
        for (int i = 0; i < 65526; i++) begin
            c = c + 16'd1;
            push(a, c);
            a = a + 32'd2;
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
        end
        chk("wrap_cnt", {16'h0, FETCH_CNT}, 32'h0);

        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        RST = 1'b1;
        #1;
        chk("async_rst_pc", PC, 32'h100);
        chk("async_rst_valid", {31'h0, ID_VALID}, 32'h0);
        chk("async_rst_cnt", {16'h0, FETCH_CNT}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        push(32'h100, 16'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_stall_id_pc", ID_PC, 32'h100);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL use one clock; reset is asynchronous and active-high; ports named CLK and RST.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-005 SHALL have port IF_PC  input  32  next PC from the fetch datapath (incremented or relative-branch).
REQ-006 SHALL have port FINST  input  16  fetched Thumb instruction from the fetch datapath; 16'h0000 when the fetch datapath squashes.
REQ-007 SHALL have port INST_VALID  input  1  memory read data for address PC is present this cycle; present for one cycle only.
REQ-008 SHALL have port STALL  input  1  decode/hazard stage cannot accept a new instruction.
REQ-009 SHALL have port FLUSH  input  1  downstream redirect (absolute branch, exception).
REQ-010 SHALL have port FLUSH_PC  input  32  redirect target.
REQ-011 SHALL have port PC  output  32  current fetch address to memory and fetch datapath.
REQ-012 SHALL have port ID_PC  output  32  address of the instruction held in ID.
REQ-013 SHALL have port ID_INST  output  16  instruction to decode; 16'h0000 when ID_VALID=0.
REQ-014 SHALL have port ID_VALID  output  1  ID holds a real instruction.
REQ-015 SHALL have port FETCH_CNT  output  16  count of instructions delivered to ID.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, HOLD.
REQ-017 BOOT SHALL last one cycle with no instruction accepted (memory latency), then go to RUN.
REQ-018 In RUN with INST_VALID=1, STALL=0: ID_PC<=PC, ID_INST<=FINST, ID_VALID<=1, PC<=IF_PC, FETCH_CNT+1.
REQ-019 In RUN with INST_VALID=1, STALL=1: skid<={PC,FINST}, PC<=IF_PC, ID holds, next state HOLD.
REQ-020 In RUN with INST_VALID=0, STALL=0: ID_VALID<=0, ID_INST<=0, PC holds, ID_PC holds.
REQ-021 In RUN with INST_VALID=0, STALL=1: ID and PC hold.
REQ-022 In HOLD: PC and ID hold while STALL=1; INST_VALID ignored.
REQ-023 In HOLD with STALL=0: ID<={skid,valid=1}, FETCH_CNT+1, skid cleared, no new fetch accepted that cycle, next state RUN.
REQ-024 FLUSH=1 in any state SHALL take priority over STALL and INST_VALID: PC<=FLUSH_PC, ID_VALID<=0, ID_INST<=0, skid cleared, next state BOOT.
REQ-025 PC bit 0 SHALL always be 0; bit 0 of IF_PC and FLUSH_PC is ignored.
REQ-026 FETCH_CNT SHALL wrap 16'hFFFF -> 16'h0000.
REQ-027 The skid buffer SHALL hold exactly one entry; the instruction in flight at stall onset is never lost or duplicated.

Reset
REQ-028 While RST=1: PC=RESET_VECTOR, ID_PC=0, ID_INST=0, ID_VALID=0, FETCH_CNT=0, skid empty, state BOOT.
REQ-029 Reset asserted mid-stall or mid-flush SHALL discard the skid and pending redirect immediately.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the bubble constant 16'h0000.
REQ-031 No sub-module is required; the skid entry is local registers inside if_id_pipe.

Verification
REQ-032 Reset release, RESET_VECTOR=32'h100, INST_VALID=1 -> ID_VALID=0 in the BOOT cycle; first valid ID_PC=32'h100 on the following edge.
REQ-033 Streaming 4 fetches 0x100..0x106 with no stall -> ID_PC 0x100,0x102,0x104,0x106 on consecutive cycles; FETCH_CNT=4.
REQ-034 STALL raised for 3 cycles while fetch at 0x104 is valid -> skid holds 0x104, PC=0x106, ID frozen at 0x102; on release ID_PC=0x104, then 0x106 one cycle later.
REQ-035 FLUSH with FLUSH_PC=32'h201 during HOLD -> PC=32'h200, ID_VALID=0, skid empty, state BOOT; next valid ID_PC=32'h200.
REQ-036 FETCH_CNT preloaded to 16'hFFFF via 65535 deliveries, one more -> 16'h0000.
